// File: rtl/hqm_aw_rf_2048x25_ctl_pkg.sv
// ----------------------------------------------------------------------------
// hqm_aw_rf_2048x25_ctl_pkg : shared types, sizes and parity helper
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package hqm_aw_rf_2048x25_ctl_pkg;

  localparam int DEPTH  = 2048;
  localparam int AWIDTH = 11;
  localparam int DWIDTH = 25;

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    READY = 1'b1
  } rf_ctl_state_t;

  // Stored word: top bit replaced by even parity of the payload when enabled.
  function automatic logic [DWIDTH-1:0] par_gen(input logic [DWIDTH-1:0] d);
`ifdef HQM_AW_RF_CTL_PAR_EN
    par_gen = {^d[DWIDTH-2:0], d[DWIDTH-2:0]};
`else
    par_gen = d;
`endif
  endfunction

endpackage

`default_nettype wire

// File: rtl/hqm_aw_rf_2048x25_ctl_rr_arb2.sv
// ----------------------------------------------------------------------------
// hqm_aw_rf_2048x25_ctl_rr_arb2 : 2-way round-robin arbiter, combinational grant
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module hqm_aw_rf_2048x25_ctl_rr_arb2 (
  input  logic       rclk,
  input  logic       rclk_rst_n,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic rr_q;
  logic rr_d;

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = rr_q ? 2'b10 : 2'b01;
        default: gnt_o = 2'b00;
      endcase
    end
    // Favour the client that was not just served.
    rr_d = rr_q;
    if (|gnt_o) rr_d = gnt_o[0];
  end

  always_ff @(posedge rclk or negedge rclk_rst_n) begin
    if (!rclk_rst_n) rr_q <= 1'b0;
    else             rr_q <= rr_d;
  end

endmodule

`default_nettype wire

// File: rtl/hqm_aw_rf_2048x25_ctl.sv
// ----------------------------------------------------------------------------
// hqm_aw_rf_2048x25_ctl : init + 2-client arbitration for a 2048x25 RF macro
// Optional parity: HQM_AW_RF_CTL_PAR_EN.  Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module hqm_aw_rf_2048x25_ctl
  import hqm_aw_rf_2048x25_ctl_pkg::*;
#(
  parameter logic [DWIDTH-1:0] INIT_VAL = '0
) (
  input  logic                rclk,
  input  logic                rclk_rst_n,
  input  logic                cfg_init_i,
  output logic                init_done_o,
  input  logic [1:0]          c_we_i,
  input  logic [2*AWIDTH-1:0] c_waddr_i,
  input  logic [2*DWIDTH-1:0] c_wdata_i,
  output logic [1:0]          c_wgnt_o,
  input  logic [1:0]          c_re_i,
  input  logic [2*AWIDTH-1:0] c_raddr_i,
  output logic [1:0]          c_rgnt_o,
  output logic                rd_v_o,
  output logic                rd_id_o,
  output logic [DWIDTH-1:0]   rd_data_o,
  output logic                par_err_o,
  output logic                mem_we_o,
  output logic [AWIDTH-1:0]   mem_waddr_o,
  output logic [DWIDTH-1:0]   mem_wdata_o,
  output logic                mem_re_o,
  output logic [AWIDTH-1:0]   mem_raddr_o,
  input  logic [DWIDTH-1:0]   mem_rdata_i
);

  rf_ctl_state_t     state_q, state_d;
  logic [AWIDTH-1:0] init_ptr_q, init_ptr_d;
  logic              rd_v_q, rd_id_q;
  logic              grant_en;

  assign grant_en    = (state_q == READY);
  assign init_done_o = grant_en;

  hqm_aw_rf_2048x25_ctl_rr_arb2 u_warb (
    .rclk       (rclk),
    .rclk_rst_n (rclk_rst_n),
    .en_i       (grant_en),
    .req_i      (c_we_i),
    .gnt_o      (c_wgnt_o)
  );

  hqm_aw_rf_2048x25_ctl_rr_arb2 u_rarb (
    .rclk       (rclk),
    .rclk_rst_n (rclk_rst_n),
    .en_i       (grant_en),
    .req_i      (c_re_i),
    .gnt_o      (c_rgnt_o)
  );

  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    case (state_q)
      INIT: begin
        init_ptr_d = init_ptr_q + 1'b1;
        if (init_ptr_q == AWIDTH'(DEPTH - 1)) state_d = READY;
      end
      READY: begin
        if (cfg_init_i) begin
          state_d    = INIT;
          init_ptr_d = '0;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_comb begin
    mem_we_o    = 1'b0;
    mem_waddr_o = '0;
    mem_wdata_o = '0;
    if (state_q == INIT) begin
      mem_we_o    = 1'b1;
      mem_waddr_o = init_ptr_q;
      mem_wdata_o = par_gen(INIT_VAL);
    end else if (c_wgnt_o[1]) begin
      mem_we_o    = 1'b1;
      mem_waddr_o = c_waddr_i[AWIDTH +: AWIDTH];
      mem_wdata_o = par_gen(c_wdata_i[DWIDTH +: DWIDTH]);
    end else if (c_wgnt_o[0]) begin
      mem_we_o    = 1'b1;
      mem_waddr_o = c_waddr_i[0 +: AWIDTH];
      mem_wdata_o = par_gen(c_wdata_i[0 +: DWIDTH]);
    end
  end

  always_comb begin
    mem_re_o    = |c_rgnt_o;
    mem_raddr_o = '0;
    if (c_rgnt_o[1])      mem_raddr_o = c_raddr_i[AWIDTH +: AWIDTH];
    else if (c_rgnt_o[0]) mem_raddr_o = c_raddr_i[0 +: AWIDTH];
  end

  always_ff @(posedge rclk or negedge rclk_rst_n) begin
    if (!rclk_rst_n) begin
      state_q    <= INIT;
      init_ptr_q <= '0;
      rd_v_q     <= 1'b0;
      rd_id_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
      rd_v_q     <= mem_re_o;
      rd_id_q    <= c_rgnt_o[1];
    end
  end

  // The macro presents data the clock after mem_re, aligned with rd_v.
  assign rd_v_o    = rd_v_q;
  assign rd_id_o   = rd_id_q;
  assign rd_data_o = rd_v_q ? mem_rdata_i : '0;

`ifdef HQM_AW_RF_CTL_PAR_EN
  assign par_err_o = rd_v_q & (mem_rdata_i[DWIDTH-1] ^ (^mem_rdata_i[DWIDTH-2:0]));
`else
  assign par_err_o = 1'b0;
`endif

endmodule

`default_nettype wire
